// File: rtl/ext_gpio_irq_ctl_if.sv
// rtl/ext_gpio_irq_ctl_if.sv - op/rw/addr slave bus bundle for the GPIO controller
// One access per cycle when op=1; data_r is registered inside the slave.
interface ext_gpio_irq_ctl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  op;
   logic                  rw;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data_w;
   logic [DATA_WIDTH-1:0] data_r;

   modport master (
      output op,
      output rw,
      output addr,
      output data_w,
      input  data_r
   );

   modport slave (
      input  op,
      input  rw,
      input  addr,
      input  data_w,
      output data_r
   );
endinterface

// File: rtl/ext_gpio_irq_ctl.sv
// rtl/ext_gpio_irq_ctl.sv - GPIO controller with direction, atomic set/clr/tgl and edge interrupts
// All state advances on the falling edge of sys_clk; sys_rst is asynchronous active-low.
module ext_gpio_irq_ctl #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    GPIO_WIDTH  = 32,
   parameter int                    SYNC_STAGES = 2,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'hf0000000
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   ext_gpio_irq_ctl_if.slave     bus,
   input  logic [GPIO_WIDTH-1:0] gpio_in,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   output logic [GPIO_WIDTH-1:0] gpio_oe,
   output logic                  irq
);
   localparam logic [7:0] OFF_IN      = 8'h00;
   localparam logic [7:0] OFF_OUT     = 8'h04;
   localparam logic [7:0] OFF_OUT_SET = 8'h08;
   localparam logic [7:0] OFF_OUT_CLR = 8'h0C;
   localparam logic [7:0] OFF_OUT_TGL = 8'h10;
   localparam logic [7:0] OFF_DIR     = 8'h14;
   localparam logic [7:0] OFF_IRQ_EN  = 8'h18;
   localparam logic [7:0] OFF_RISE_EN = 8'h1C;
   localparam logic [7:0] OFF_FALL_EN = 8'h20;
   localparam logic [7:0] OFF_PEND    = 8'h24;

   logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] r_sync;
   logic [GPIO_WIDTH-1:0] r_prev;
   logic [GPIO_WIDTH-1:0] r_out;
   logic [GPIO_WIDTH-1:0] r_dir;
   logic [GPIO_WIDTH-1:0] r_irq_en;
   logic [GPIO_WIDTH-1:0] r_rise_en;
   logic [GPIO_WIDTH-1:0] r_fall_en;
   logic [GPIO_WIDTH-1:0] r_pend;

   logic [ADDR_WIDTH-1:0] w_delta;
   logic                  w_in_win;
   logic [7:0]            w_off;
   logic                  w_wr;
   logic                  w_rd;
   logic [GPIO_WIDTH-1:0] w_wdata;
   logic [GPIO_WIDTH-1:0] w_sync;
   logic [GPIO_WIDTH-1:0] w_edge_set;
   logic [GPIO_WIDTH-1:0] w_pend_clr;
   logic [GPIO_WIDTH-1:0] w_out_next;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_unused_wdata;

   // Offset from the base so an unaligned BASE_ADDR still yields a 256-byte window.
   assign w_delta  = bus.addr - BASE_ADDR;
   assign w_in_win = (w_delta[ADDR_WIDTH-1:8] == '0);
   assign w_off    = w_delta[7:0];
   assign w_wr     = bus.op &  bus.rw & w_in_win;
   assign w_rd     = bus.op & ~bus.rw & w_in_win;
   assign w_wdata  = bus.data_w[GPIO_WIDTH-1:0];
   assign w_unused_wdata = &{1'b0, bus.data_w};

   assign w_sync     = r_sync[SYNC_STAGES-1];
   assign w_edge_set = (w_sync & ~r_prev & r_rise_en) | (~w_sync & r_prev & r_fall_en);
   assign w_pend_clr = (w_wr && (w_off == OFF_PEND)) ? w_wdata : '0;

   always_comb begin
      w_out_next = r_out;
      if (w_wr) begin
         case (w_off)
            OFF_OUT:     w_out_next = w_wdata;
            OFF_OUT_SET: w_out_next = r_out | w_wdata;
            OFF_OUT_CLR: w_out_next = r_out & ~w_wdata;
            OFF_OUT_TGL: w_out_next = r_out ^ w_wdata;
            default:     w_out_next = r_out;
         endcase
      end
   end

   // Read data is zero-extended; write-only and unmapped offsets read as 0.
   always_comb begin
      w_rd_data = '0;
      case (w_off)
         OFF_IN:      w_rd_data[GPIO_WIDTH-1:0] = w_sync;
         OFF_OUT:     w_rd_data[GPIO_WIDTH-1:0] = r_out;
         OFF_DIR:     w_rd_data[GPIO_WIDTH-1:0] = r_dir;
         OFF_IRQ_EN:  w_rd_data[GPIO_WIDTH-1:0] = r_irq_en;
         OFF_RISE_EN: w_rd_data[GPIO_WIDTH-1:0] = r_rise_en;
         OFF_FALL_EN: w_rd_data[GPIO_WIDTH-1:0] = r_fall_en;
         OFF_PEND:    w_rd_data[GPIO_WIDTH-1:0] = r_pend;
         default:     w_rd_data = '0;
      endcase
   end

   always_ff @(negedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_sync     <= '0;
         r_prev     <= '0;
         r_out      <= '0;
         r_dir      <= '0;
         r_irq_en   <= '0;
         r_rise_en  <= '0;
         r_fall_en  <= '0;
         r_pend     <= '0;
         bus.data_r <= '0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], gpio_in};
         r_prev     <= w_sync;
         r_out      <= w_out_next;
         // A new edge outranks a same-edge W1C on the same bit.
         r_pend     <= (r_pend & ~w_pend_clr) | w_edge_set;
         bus.data_r <= w_rd ? w_rd_data : '0;
         if (w_wr) begin
            case (w_off)
               OFF_DIR:     r_dir     <= w_wdata;
               OFF_IRQ_EN:  r_irq_en  <= w_wdata;
               OFF_RISE_EN: r_rise_en <= w_wdata;
               OFF_FALL_EN: r_fall_en <= w_wdata;
               default:     ;
            endcase
         end
      end
   end

   assign gpio_out = r_out;
   assign gpio_oe  = r_dir;
   assign irq      = |(r_pend & r_irq_en);
endmodule

// File: tb/tb_ext_gpio_irq_ctl.sv
// tb/tb_ext_gpio_irq_ctl.sv - vector-table and sequence bench for ext_gpio_irq_ctl
// Inputs change just after a falling edge; outputs are sampled 1ns after it.
module tb_ext_gpio_irq_ctl;
   localparam logic [31:0] B = 32'hf0000000;

   logic        sys_clk;
   logic        sys_rst;
   logic [31:0] pins0;
   logic [7:0]  pins1;
   logic [31:0] gpio_out0, gpio_oe0;
   logic [7:0]  gpio_out1, gpio_oe1;
   logic        irq0, irq1;
   int          n_cmp;
   int          n_err;
   logic [31:0] rd;

   ext_gpio_irq_ctl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   ext_gpio_irq_ctl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

   ext_gpio_irq_ctl #(.GPIO_WIDTH(32)) dut0 (
      .sys_clk (sys_clk), .sys_rst (sys_rst), .bus (bus0),
      .gpio_in (pins0), .gpio_out (gpio_out0), .gpio_oe (gpio_oe0), .irq (irq0)
   );

   ext_gpio_irq_ctl #(.GPIO_WIDTH(8)) dut1 (
      .sys_clk (sys_clk), .sys_rst (sys_rst), .bus (bus1),
      .gpio_in (pins1), .gpio_out (gpio_out1), .gpio_oe (gpio_oe1), .irq (irq1)
   );

   initial begin
      sys_clk = 1'b1;
      forever #5 sys_clk = ~sys_clk;
   end

   typedef struct {
      logic        op;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pins;
      logic [31:0] exp_r;
      logic [31:0] exp_out;
      logic [31:0] exp_oe;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic wr0(input logic [31:0] a, input logic [31:0] d);
      bus0.op = 1'b1; bus0.rw = 1'b1; bus0.addr = a; bus0.data_w = d;
      cyc();
      bus0.op = 1'b0; bus0.rw = 1'b0;
   endtask

   task automatic rd0(input logic [31:0] a, output logic [31:0] d);
      bus0.op = 1'b1; bus0.rw = 1'b0; bus0.addr = a;
      cyc();
      d = bus0.data_r;
      bus0.op = 1'b0;
   endtask

   task automatic wr1(input logic [31:0] a, input logic [31:0] d);
      bus1.op = 1'b1; bus1.rw = 1'b1; bus1.addr = a; bus1.data_w = d;
      cyc();
      bus1.op = 1'b0; bus1.rw = 1'b0;
   endtask

   task automatic rd1(input logic [31:0] a, output logic [31:0] d);
      bus1.op = 1'b1; bus1.rw = 1'b0; bus1.addr = a;
      cyc();
      d = bus1.data_r;
      bus1.op = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      //             op rw addr          wdata          pins           exp_r          exp_out    exp_oe         irq
      vecs[0]  = '{1'b1, 1'b0, B+32'h00, 32'h0,         32'hFFFFFFFF, 32'h0,         32'h0,     32'h0,         1'b0};
      vecs[1]  = '{1'b1, 1'b0, B+32'h00, 32'h0,         32'hFFFFFFFF, 32'h0,         32'h0,     32'h0,         1'b0};
      vecs[2]  = '{1'b1, 1'b0, B+32'h00, 32'h0,         32'hFFFFFFFF, 32'hFFFFFFFF,  32'h0,     32'h0,         1'b0};
      vecs[3]  = '{1'b1, 1'b1, B+32'h04, 32'h000000F0,  32'hFFFFFFFF, 32'h0,         32'hF0,    32'h0,         1'b0};
      vecs[4]  = '{1'b1, 1'b1, B+32'h08, 32'h0000000F,  32'hFFFFFFFF, 32'h0,         32'hFF,    32'h0,         1'b0};
      vecs[5]  = '{1'b1, 1'b1, B+32'h0C, 32'h00000030,  32'hFFFFFFFF, 32'h0,         32'hCF,    32'h0,         1'b0};
      vecs[6]  = '{1'b1, 1'b1, B+32'h10, 32'h00000101,  32'hFFFFFFFF, 32'h0,         32'h1CE,   32'h0,         1'b0};
      vecs[7]  = '{1'b1, 1'b0, B+32'h04, 32'h0,         32'hFFFFFFFF, 32'h1CE,       32'h1CE,   32'h0,         1'b0};
      vecs[8]  = '{1'b1, 1'b0, B+32'h08, 32'h0,         32'hFFFFFFFF, 32'h0,         32'h1CE,   32'h0,         1'b0};
      vecs[9]  = '{1'b1, 1'b0, B+32'h0C, 32'h0,         32'hFFFFFFFF, 32'h0,         32'h1CE,   32'h0,         1'b0};
      vecs[10] = '{1'b1, 1'b0, B+32'h10, 32'h0,         32'hFFFFFFFF, 32'h0,         32'h1CE,   32'h0,         1'b0};
      vecs[11] = '{1'b1, 1'b1, B+32'h14, 32'h0000FFFF,  32'hFFFFFFFF, 32'h0,         32'h1CE,   32'h0000FFFF,  1'b0};
      vecs[12] = '{1'b1, 1'b0, B+32'h14, 32'h0,         32'hFFFFFFFF, 32'h0000FFFF,  32'h1CE,   32'h0000FFFF,  1'b0};
      vecs[13] = '{1'b1, 1'b0, B+32'h28, 32'h0,         32'hFFFFFFFF, 32'h0,         32'h1CE,   32'h0000FFFF,  1'b0};
      vecs[14] = '{1'b1, 1'b1, B+32'h80, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h0,         32'h1CE,   32'h0000FFFF,  1'b0};
      vecs[15] = '{1'b1, 1'b1, B+32'h104, 32'h0,        32'hFFFFFFFF, 32'h0,         32'h1CE,   32'h0000FFFF,  1'b0};
      vecs[16] = '{1'b1, 1'b0, 32'he0000004, 32'h0,     32'hFFFFFFFF, 32'h0,         32'h1CE,   32'h0000FFFF,  1'b0};
      vecs[17] = '{1'b0, 1'b0, B+32'h04, 32'h0,         32'hFFFFFFFF, 32'h0,         32'h1CE,   32'h0000FFFF,  1'b0};
      vecs[18] = '{1'b1, 1'b0, B+32'h04, 32'h0,         32'hFFFFFFFF, 32'h1CE,       32'h1CE,   32'h0000FFFF,  1'b0};
      vecs[19] = '{1'b1, 1'b0, B+32'h24, 32'h0,         32'hFFFFFFFF, 32'h0,         32'h1CE,   32'h0000FFFF,  1'b0};
      vecs[20] = '{1'b1, 1'b0, B+32'h00, 32'h0,         32'hFFFFFFFF, 32'hFFFFFFFF,  32'h1CE,   32'h0000FFFF,  1'b0};

      bus0.op = 1'b0; bus0.rw = 1'b0; bus0.addr = '0; bus0.data_w = '0;
      bus1.op = 1'b0; bus1.rw = 1'b0; bus1.addr = '0; bus1.data_w = '0;
      pins0 = 32'hFFFFFFFF;
      pins1 = 8'h00;
      sys_rst = 1'b0;
      idle(3);
      chk("rst.data_r", bus0.data_r, 32'h0);
      chk("rst.gpio_out", gpio_out0, 32'h0);
      chk("rst.gpio_oe", gpio_oe0, 32'h0);
      chk("rst.irq", {31'h0, irq0}, 32'h0);
      chk("rst.w8_out", {24'h0, gpio_out1}, 32'h0);
      sys_rst = 1'b1;

      for (int i = 0; i < 21; i++) begin
         bus0.op = vecs[i].op; bus0.rw = vecs[i].rw;
         bus0.addr = vecs[i].addr; bus0.data_w = vecs[i].wdata;
         pins0 = vecs[i].pins;
         cyc();
         chk($sformatf("vec%0d.data_r", i), bus0.data_r, vecs[i].exp_r);
         chk($sformatf("vec%0d.gpio_out", i), gpio_out0, vecs[i].exp_out);
         chk($sformatf("vec%0d.gpio_oe", i), gpio_oe0, vecs[i].exp_oe);
         chk($sformatf("vec%0d.irq", i), {31'h0, irq0}, {31'h0, vecs[i].exp_irq});
      end
      bus0.op = 1'b0; bus0.rw = 1'b0;

      // Rising edge on pin0 with interrupt enabled.
      pins0 = 32'h0;
      idle(4);
      rd0(B+32'h24, rd); chk("fall_noen.pend", rd, 32'h0);
      wr0(B+32'h1C, 32'h1);
      wr0(B+32'h18, 32'h1);
      chk("rise.irq_pre", {31'h0, irq0}, 32'h0);
      pins0 = 32'h1;
      cyc(); chk("rise.irq_e1", {31'h0, irq0}, 32'h0);
      cyc(); chk("rise.irq_e2", {31'h0, irq0}, 32'h0);
      cyc(); chk("rise.irq_e3", {31'h0, irq0}, 32'h1);
      pins0 = 32'h0;
      idle(4);
      chk("rise.irq_after_fall", {31'h0, irq0}, 32'h1);
      rd0(B+32'h24, rd); chk("rise.pend", rd, 32'h1);
      wr0(B+32'h24, 32'h1);
      chk("rise.irq_w1c", {31'h0, irq0}, 32'h0);
      rd0(B+32'h24, rd); chk("rise.pend_w1c", rd, 32'h0);

      // Falling edge pends while masked; enabling later raises irq.
      wr0(B+32'h20, 32'h2);
      wr0(B+32'h18, 32'h0);
      pins0 = 32'h2;
      idle(4);
      rd0(B+32'h24, rd); chk("fall.pend_on_rise", rd, 32'h0);
      pins0 = 32'h0;
      idle(4);
      rd0(B+32'h24, rd); chk("fall.pend", rd, 32'h2);
      chk("fall.irq_masked", {31'h0, irq0}, 32'h0);
      wr0(B+32'h18, 32'h2);
      chk("fall.irq_enabled", {31'h0, irq0}, 32'h1);
      wr0(B+32'h24, 32'h2);
      chk("fall.irq_w1c", {31'h0, irq0}, 32'h0);

      // W1C on the same edge that a new rise registers: set wins.
      pins0 = 32'h1;
      idle(4);
      rd0(B+32'h24, rd); chk("race.pend_set", rd, 32'h1);
      wr0(B+32'h24, 32'h1);
      rd0(B+32'h24, rd); chk("race.pend_cleared", rd, 32'h0);
      pins0 = 32'h0;
      idle(4);
      pins0 = 32'h1;
      cyc();
      cyc();
      wr0(B+32'h24, 32'h1);
      rd0(B+32'h24, rd); chk("race.set_wins", rd, 32'h1);
      wr0(B+32'h24, 32'h1);
      rd0(B+32'h24, rd); chk("race.w1c_alone", rd, 32'h0);

      // Narrow instance: upper bits dropped, stray accesses ignored.
      wr1(B+32'h04, 32'hFFFFFFFF);
      chk("w8.gpio_out", {24'h0, gpio_out1}, 32'hFF);
      rd1(B+32'h04, rd); chk("w8.out_read", rd, 32'h000000FF);
      wr1(32'he0000004, 32'h0);
      rd1(B+32'h04, rd); chk("w8.out_outside_wr", rd, 32'h000000FF);
      rd1(B+32'h80, rd); chk("w8.rd_0x80", rd, 32'h0);
      rd1(B+32'h04, rd); chk("w8.out_after_0x80", rd, 32'h000000FF);
      wr1(B+32'h14, 32'hFFFFFFFF);
      chk("w8.gpio_oe", {24'h0, gpio_oe1}, 32'hFF);
      rd1(B+32'h14, rd); chk("w8.dir_read", rd, 32'h000000FF);

      // Asynchronous reset in the middle of a write.
      bus0.op = 1'b1; bus0.rw = 1'b1; bus0.addr = B+32'h04; bus0.data_w = 32'h5A5A5A5A;
      #2 sys_rst = 1'b0;
      #1;
      chk("arst.gpio_out", gpio_out0, 32'h0);
      chk("arst.gpio_oe", gpio_oe0, 32'h0);
      chk("arst.w8_out", {24'h0, gpio_out1}, 32'h0);
      cyc();
      chk("arst.gpio_out_held", gpio_out0, 32'h0);
      bus0.op = 1'b0; bus0.rw = 1'b0;
      sys_rst = 1'b1;
      idle(4);
      rd0(B+32'h24, rd); chk("arst.pend", rd, 32'h0);
      rd0(B+32'h04, rd); chk("arst.out", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
